// File: rtl/wsp_sequencer.sv
// wsp_sequencer: autonomous IEEE 1500 WSP driver running one WIR load or WDR scan per command
module wsp_sequencer #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               WRCK,
  input  logic               WRSTN,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_wir,
  input  logic               cmd_capture,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               busy,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               SelectWIR,
  output logic               CaptureWR,
  output logic               ShiftWR,
  output logic               UpdateWR,
  output logic               WSI,
  input  logic               WSO
);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, CAPTURE = 3'd2, SHIFT = 3'd3, UPDATE = 3'd4, DONE = 3'd5;
  logic [2:0]         state, state_nx;
  logic               wir, cap, wir_nx, acc;
  logic [LEN_W-1:0]   rem, len_c;
  logic [MAX_LEN-1:0] dat, msk;
  // next state; outputs are then registered from it so nothing reaches a pin combinationally
  always_comb begin
    acc      = state == IDLE && cmd_valid;
    wir_nx   = state == IDLE ? cmd_wir : wir;
    len_c    = cmd_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : cmd_len;
    state_nx = state == IDLE    ? (cmd_valid ? SETUP : IDLE) :
               state == SETUP   ? (cap ? CAPTURE : rem == '0 ? UPDATE : SHIFT) :
               state == CAPTURE ? (rem == '0 ? UPDATE : SHIFT) :
               state == SHIFT   ? (rem == LEN_W'(1) ? UPDATE : SHIFT) :
               state == UPDATE  ? DONE : IDLE;
  end
  // command latch, shift datapath and registered WSP controls
  always_ff @(posedge WRCK or negedge WRSTN) begin
    if (!WRSTN) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      SelectWIR <= 1'b0;
      CaptureWR <= 1'b0;
      ShiftWR   <= 1'b0;
      UpdateWR  <= 1'b0;
      WSI       <= 1'b0;
      wir       <= 1'b0;
      cap       <= 1'b0;
      rem       <= '0;
      dat       <= '0;
      msk       <= '0;
    end else begin
      state     <= state_nx;
      cmd_ready <= state_nx == IDLE;
      busy      <= state_nx != IDLE;
      rsp_valid <= state_nx == DONE;
      SelectWIR <= state_nx != IDLE && wir_nx;
      CaptureWR <= state_nx == CAPTURE;
      ShiftWR   <= state_nx == SHIFT;
      UpdateWR  <= state_nx == UPDATE;
      WSI       <= state_nx == SHIFT && (state == SHIFT ? dat[1] : dat[0]);
      if (acc) begin
        wir      <= cmd_wir;
        cap      <= cmd_capture;
        rem      <= len_c;
        dat      <= cmd_data;
        msk      <= MAX_LEN'(1);
        rsp_data <= '0;
      end else if (state == SHIFT) begin
        rem      <= rem - LEN_W'(1);
        dat      <= dat >> 1;
        msk      <= msk << 1;
        rsp_data <= WSO ? rsp_data | msk : rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_wsp_sequencer.sv
// tb_wsp_sequencer: directed table-driven check of the WSP sequencer
module tb_wsp_sequencer;
  logic        WRCK = 0, WRSTN = 0, cmd_valid = 0, cmd_wir = 0, cmd_capture = 0;
  logic [5:0]  cmd_len = 0;
  logic [31:0] cmd_data = 0;
  logic        cmd_ready, busy, rsp_valid, SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, WSO, wby;
  logic [31:0] rsp_data;
  int tests = 0, fails = 0, viol = 0, mode = 0;

  wsp_sequencer dut (
    .WRCK(WRCK), .WRSTN(WRSTN), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wir(cmd_wir), .cmd_capture(cmd_capture), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .SelectWIR(SelectWIR),
    .CaptureWR(CaptureWR), .ShiftWR(ShiftWR), .UpdateWR(UpdateWR), .WSI(WSI), .WSO(WSO)
  );

  always #5 WRCK = ~WRCK;

  // wrapper model: mode 0 = one-cycle bypass register, 1 = WSO high, 2 = WSO low
  always @(posedge WRCK or negedge WRSTN)
    if (!WRSTN) wby <= 1'b0;
    else wby <= WSI;
  assign WSO = mode == 0 ? wby : mode == 1;

  // strobes must be mutually exclusive and WSI idle outside shift
  always @(negedge WRCK)
    if (WRSTN && ((int'(CaptureWR) + int'(ShiftWR) + int'(UpdateWR)) > 1 || (WSI && !ShiftWR))) viol++;

  typedef struct {
    logic        wir, cap;
    logic [5:0]  len;
    logic [31:0] data;
    int          mode;
    logic [31:0] rsp, wsi;
    int          lat, nsh, ncap, nsel;
  } vec_t;
  vec_t v[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge WRCK);
    #1;
  endtask

  task automatic run(input vec_t t, input string nm);
    int n = 0, nsh = 0, ncap = 0, nupd = 0, nsel = 0, selchg = 0;
    logic [31:0] wg = 0;
    logic sel0;
    mode = t.mode;
    cmd_wir = t.wir; cmd_capture = t.cap; cmd_len = t.len; cmd_data = t.data; cmd_valid = 1;
    check({nm, " ready"}, 32'(cmd_ready), 1);
    step;
    cmd_valid = 0; cmd_data = ~t.data; cmd_wir = ~t.wir; cmd_capture = ~t.cap; cmd_len = 6'd3;
    sel0 = SelectWIR;
    while (!rsp_valid && n < 100) begin
      if (ShiftWR) begin
        if (nsh < 32) wg[nsh] = WSI;
        nsh++;
      end
      if (CaptureWR) ncap++;
      if (UpdateWR) nupd++;
      if (SelectWIR) nsel++;
      if (SelectWIR !== sel0) selchg++;
      step;
      n++;
    end
    if (SelectWIR) nsel++;
    if (SelectWIR !== sel0) selchg++;
    check({nm, " latency"}, n, t.lat);
    check({nm, " shifts"}, nsh, t.nsh);
    check({nm, " captures"}, ncap, t.ncap);
    check({nm, " updates"}, nupd, 1);
    check({nm, " sel cycles"}, nsel, t.nsel);
    check({nm, " sel steady"}, selchg, 0);
    check({nm, " wsi"}, wg, t.wsi);
    check({nm, " rsp"}, rsp_data, t.rsp);
    check({nm, " busy in done"}, 32'(busy), 1);
    step;
    check({nm, " idle"}, {cmd_ready, busy, rsp_valid, SelectWIR}, 32'b1000);
    check({nm, " rsp held"}, rsp_data, t.rsp);
  endtask

  initial begin
    int k, n, ndone, acc2, bad;
    int dn[2];
    logic [31:0] rd[2];
    logic [31:0] idle_snap;
    logic pbusy;
    //        wir   cap   len    data           mode rsp            wsi            lat nsh ncap nsel
    v[0] = '{1'b1, 1'b0, 6'd12, 32'h0000_0B14, 0, 32'h0000_0628, 32'h0000_0B14, 14, 12, 0, 15};
    v[1] = '{1'b0, 1'b1, 6'd8,  32'h0000_00A5, 0, 32'h0000_004A, 32'h0000_00A5, 11, 8,  1, 0};
    v[2] = '{1'b0, 1'b1, 6'd0,  32'h0000_FFFF, 1, 32'h0000_0000, 32'h0000_0000, 3,  0,  1, 0};
    v[3] = '{1'b0, 1'b0, 6'd40, 32'h1234_5678, 1, 32'hFFFF_FFFF, 32'h1234_5678, 34, 32, 0, 0};
    v[4] = '{1'b1, 1'b1, 6'd40, 32'hDEAD_BEEF, 0, 32'hBD5B_7DDE, 32'hDEAD_BEEF, 35, 32, 1, 36};
    v[5] = '{1'b0, 1'b0, 6'd1,  32'h0000_0001, 1, 32'h0000_0001, 32'h0000_0001, 3,  1,  0, 0};
    v[6] = '{1'b1, 1'b0, 6'd5,  32'h0000_001F, 2, 32'h0000_0000, 32'h0000_001F, 7,  5,  0, 8};
    v[7] = '{1'b1, 1'b0, 6'd0,  32'h0000_0000, 2, 32'h0000_0000, 32'h0000_0000, 2,  0,  0, 3};

    #12;
    check("reset outputs", {SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, rsp_valid}, 0);
    check("reset rsp_data", rsp_data, 0);
    @(negedge WRCK);
    WRSTN = 1;
    step;
    check("ready after reset", 32'(cmd_ready), 1);

    for (int i = 0; i < 8; i++) run(v[i], $sformatf("vec%0d", i));

    // reset asserted during shift cycle 5 of a 12-bit WIR load
    mode = 1; cmd_wir = 1; cmd_capture = 0; cmd_len = 12; cmd_data = 32'hB14; cmd_valid = 1;
    step;
    cmd_valid = 0;
    k = 0;
    while (!ShiftWR && k < 10) begin step; k++; end
    for (int i = 0; i < 5; i++) step;
    check("shift5 active", {SelectWIR, ShiftWR}, 2'b11);
    WRSTN = 0;
    #1;
    check("midrst outputs", {SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, rsp_valid}, 0);
    check("midrst rsp_data", rsp_data, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin step; if (UpdateWR || rsp_valid) bad++; end
    WRSTN = 1;
    for (int i = 0; i < 5; i++) begin step; if (UpdateWR || rsp_valid || busy) bad++; end
    check("midrst quiet", bad, 0);
    check("midrst ready", 32'(cmd_ready), 1);

    // two commands back-to-back with cmd_valid held
    mode = 0; cmd_wir = 0; cmd_capture = 0; cmd_len = 4; cmd_data = 32'h9; cmd_valid = 1;
    step;
    cmd_data = 32'h6;
    ndone = 0; acc2 = -1; dn[0] = -1; dn[1] = -1; rd[0] = '1; rd[1] = '1; idle_snap = '1; pbusy = busy;
    for (n = 0; n < 24 && ndone < 2; n++) begin
      if (rsp_valid) begin dn[ndone] = n; rd[ndone] = rsp_data; ndone++; end
      if (ndone == 2) cmd_valid = 0;
      if (n > 0 && busy && !pbusy) acc2 = n;
      if (n == 7) idle_snap = {26'b0, cmd_ready, SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI};
      pbusy = busy;
      if (ndone < 2) step;
    end
    cmd_valid = 0;
    check("b2b first done", dn[0], 6);
    check("b2b first rsp", rd[0], 32'h2);
    check("b2b idle gap", idle_snap, 32'b100000);
    check("b2b second accept", acc2, 8);
    check("b2b second done", dn[1], 14);
    check("b2b second rsp", rd[1], 32'hC);
    step;
    check("strobe exclusivity", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
